ex_agu_pipe: RTL and testbench

Pipelined, parametrised address generation unit for the execute stage. It computes `base + (ext(index) << scale)` over an `ADDR_W`-bit address space, splitting the segmented carry-select adder across two registered stages. Each stage has a valid/ready handshake, and the unit optionally flags 32-bit wrap faults. It generalises the single-cycle scaled-index AGU: wider addresses, selectable index width and extension, pipelining and backpressure.

---
 rtl/ex_agu_pipe_pkg.sv | 34 +++
 rtl/ex_agu_segadd.sv | 17 +
 rtl/ex_agu_pipe.sv | 195 +++++++++++++++++++
 tb/tb_ex_agu_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_agu_pipe_pkg.sv
// Shared definitions for the pipelined AGU: control-word field positions,
// index-width encodings and the address/segment width legality check.
package ex_agu_pipe_pkg;

    localparam int CTL_W         = 9;
    localparam int CTL_SCALE_LSB = 0;
    localparam int CTL_SCALE_W   = 2;
    localparam int CTL_ZX_BIT    = 2;
    localparam int CTL_WIDTH_LSB = 4;
    localparam int CTL_WIDTH_W   = 2;

    localparam int LO_ADDR_W = 32;

    typedef enum logic [1:0] {
        IW_B = 2'd0,
        IW_W = 2'd1,
        IW_L = 2'd2,
        IW_Q = 2'd3
    } idx_width_e;

    function automatic bit agu_cfg_legal(input int addr_w, input int seg_w);
        return (seg_w > 0) && (addr_w >= LO_ADDR_W) && ((addr_w % seg_w) == 0);
    endfunction

    function automatic int idx_bits(input idx_width_e width, input int addr_w);
        case (width)
            IW_B:    return 8;
            IW_W:    return 16;
            IW_L:    return 32;
            default: return addr_w;
        endcase
    endfunction

endpackage

// File: rtl/ex_agu_segadd.sv
// One carry-select segment: the segment sum and carry-out for both possible
// carry-ins, so the selecting chain only has to pick between them.
module ex_agu_segadd #(
    parameter int SEG_W = 16
) (
    input  logic [SEG_W-1:0] i_a,
    input  logic [SEG_W-1:0] i_b,
    output logic [SEG_W-1:0] o_sum0,
    output logic [SEG_W-1:0] o_sum1,
    output logic             o_cout0,
    output logic             o_cout1
);

    assign {o_cout0, o_sum0} = {1'b0, i_a} + {1'b0, i_b};
    assign {o_cout1, o_sum1} = {1'b0, i_a} + {1'b0, i_b} + {{SEG_W{1'b0}}, 1'b1};

endmodule

// File: rtl/ex_agu_pipe.sv
// Two-stage scaled-index address generator with valid/ready on both stages.
// Optional 32-bit wrap fault output when EXAGU_WRAPCHK_EN is defined.
module ex_agu_pipe
    import ex_agu_pipe_pkg::*;
#(
    parameter int ADDR_W = 48,
    parameter int SEG_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] regValRm,
    input  logic [ADDR_W-1:0] regValRi,
    input  logic [CTL_W-1:0]  idUIxt,
    input  logic              addrEnJq,
    input  logic              inValid,
    output logic              inReady,
    output logic              outValid,
    input  logic              outReady,
    output logic [ADDR_W-1:0] regOutAddr
`ifdef EXAGU_WRAPCHK_EN
    ,
    output logic              outFault
`endif
);

    localparam int NSEG = ADDR_W / SEG_W;
    localparam int LSEG = (NSEG + 1) / 2;
    localparam bit CFG_LEGAL = agu_cfg_legal(ADDR_W, SEG_W);
    localparam logic [ADDR_W-1:0] LO_MASK = ADDR_W'({LO_ADDR_W{1'b1}});

    if (!CFG_LEGAL) begin : g_bad_cfg
        $error("ex_agu_pipe: ADDR_W must be a multiple of SEG_W and at least 32");
    end

    idx_width_e        w_width;
    logic [1:0]        w_scale;
    logic              w_zx;
    int                w_drop;
    logic [ADDR_W-1:0] w_idx_hi;
    logic [ADDR_W-1:0] w_idx_ext;
    logic [ADDR_W-1:0] w_idx_prep;
    logic              w_ctl_unused;

    logic              w_s2_accept;
    logic              w_s1_load;
    logic              w_s2_load;
    logic [ADDR_W-1:0] w_s2_sum;
    logic [ADDR_W-1:0] w_addr_masked;
    logic              w_carry_unused;

    logic              r_s1_valid;
    logic              r_s1_en;
    logic              r_s1_carry;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;

    assign w_ctl_unused = ^{idUIxt[8:6], idUIxt[3]};

    // Left-justify the kept index field, then shift back down so the
    // logical/arithmetic right shift performs the zero/sign extension.
    always_comb begin
        w_width    = idx_width_e'(idUIxt[CTL_WIDTH_LSB +: CTL_WIDTH_W]);
        w_scale    = idUIxt[CTL_SCALE_LSB +: CTL_SCALE_W];
        w_zx       = idUIxt[CTL_ZX_BIT];
        w_drop     = ADDR_W - idx_bits(w_width, ADDR_W);
        w_idx_hi   = regValRi << w_drop;
        if (w_zx) begin
            w_idx_ext = w_idx_hi >> w_drop;
        end else begin
            w_idx_ext = $signed(w_idx_hi) >>> w_drop;
        end
        w_idx_prep = w_idx_ext << w_scale;
    end

    assign w_s2_accept = !r_out_valid || outReady;
    assign inReady     = !r_s1_valid || w_s2_accept;
    assign w_s1_load   = inValid && inReady;
    assign w_s2_load   = r_s1_valid && w_s2_accept;

    // Segments below LSEG add the live request in S1; the rest add the
    // operands S1 registered, seeded by the carry S1 saved.
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
        logic [SEG_W-1:0] w_a;
        logic [SEG_W-1:0] w_b;
        logic [SEG_W-1:0] w_sum0;
        logic [SEG_W-1:0] w_sum1;
        logic [SEG_W-1:0] w_sum;
        logic             w_c0;
        logic             w_c1;
        logic             w_cin;
        logic             w_co;

        ex_agu_segadd #(.SEG_W(SEG_W)) u_segadd (
            .i_a     (w_a),
            .i_b     (w_b),
            .o_sum0  (w_sum0),
            .o_sum1  (w_sum1),
            .o_cout0 (w_c0),
            .o_cout1 (w_c1)
        );

        assign w_sum = w_cin ? w_sum1 : w_sum0;
        assign w_co  = w_cin ? w_c1 : w_c0;

        if (gi < LSEG) begin : g_lo
            logic [SEG_W-1:0] r_sum;

            assign w_a = regValRm[gi*SEG_W +: SEG_W];
            assign w_b = w_idx_prep[gi*SEG_W +: SEG_W];
            if (gi == 0) begin : g_first
                assign w_cin = 1'b0;
            end else begin : g_chain
                assign w_cin = g_seg[gi-1].w_co;
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_sum <= '0;
                end else if (w_s1_load) begin
                    r_sum <= w_sum;
                end
            end

            assign w_s2_sum[gi*SEG_W +: SEG_W] = r_sum;
        end else begin : g_hi
            logic [SEG_W-1:0] r_a;
            logic [SEG_W-1:0] r_b;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_s1_load) begin
                    r_a <= regValRm[gi*SEG_W +: SEG_W];
                    r_b <= w_idx_prep[gi*SEG_W +: SEG_W];
                end
            end

            assign w_a = r_a;
            assign w_b = r_b;
            if (gi == LSEG) begin : g_first
                assign w_cin = r_s1_carry;
            end else begin : g_chain
                assign w_cin = g_seg[gi-1].w_co;
            end

            assign w_s2_sum[gi*SEG_W +: SEG_W] = w_sum;
        end
    end

    assign w_carry_unused = g_seg[NSEG-1].w_co;
    assign w_addr_masked  = w_s2_sum & (r_s1_en ? {ADDR_W{1'b1}} : LO_MASK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_en     <= 1'b0;
            r_s1_carry  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
                r_s1_en    <= addrEnJq;
                r_s1_carry <= g_seg[LSEG-1].w_co;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_accept) begin
                r_out_valid <= r_s1_valid;
            end
            if (w_s2_load) begin
                r_out_addr <= w_addr_masked;
            end
        end
    end

    assign outValid   = r_out_valid;
    assign regOutAddr = r_out_addr;

`ifdef EXAGU_WRAPCHK_EN
    logic r_out_fault;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_fault <= 1'b0;
        end else if (w_s2_load) begin
            r_out_fault <= !r_s1_en && (|(w_s2_sum & ~LO_MASK));
        end
    end

    assign outFault = r_out_fault;
`endif

endmodule

// File: tb/tb_ex_agu_pipe.sv
// Self-checking bench for ex_agu_pipe: directed vectors, backpressure,
// streaming, randomized traffic against a queue-based reference model.
module tb_ex_agu_pipe;

    localparam int AW = 48;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] regValRm;
    logic [AW-1:0] regValRi;
    logic [8:0]    idUIxt;
    logic          addrEnJq;
    logic          inValid;
    logic          inReady;
    logic          outValid;
    logic          outReady;
    logic [AW-1:0] regOutAddr;
`ifdef EXAGU_WRAPCHK_EN
    logic          outFault;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    logic [AW:0]   exp_q[$];
    logic [AW:0]   exp_e;
    logic          hold_pend = 1'b0;
    logic [AW-1:0] hold_addr;

    always #5 clock = ~clock;

    ex_agu_pipe #(.ADDR_W(AW), .SEG_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .regValRm   (regValRm),
        .regValRi   (regValRi),
        .idUIxt     (idUIxt),
        .addrEnJq   (addrEnJq),
        .inValid    (inValid),
        .inReady    (inReady),
        .outValid   (outValid),
        .outReady   (outReady),
        .regOutAddr (regOutAddr)
`ifdef EXAGU_WRAPCHK_EN
        ,
        .outFault   (outFault)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the extended, scaled index.
    function automatic logic [AW:0] ref_agu(input logic [AW-1:0] b, input logic [AW-1:0] x,
                                            input logic [8:0] c, input logic en);
        logic [63:0] v;
        logic [63:0] full;
        logic        f;
        case (c[5:4])
            2'd0:    v = c[2] ? 64'(x[7:0])  : 64'($signed(x[7:0]));
            2'd1:    v = c[2] ? 64'(x[15:0]) : 64'($signed(x[15:0]));
            2'd2:    v = c[2] ? 64'(x[31:0]) : 64'($signed(x[31:0]));
            default: v = c[2] ? 64'(x)       : 64'($signed(x));
        endcase
        full = (64'(b) + (v << c[1:0])) & ((64'd1 << AW) - 64'd1);
        f    = !en && (full[63:32] != 32'd0);
        if (!en) full = full & 64'hFFFF_FFFF;
        return {f, full[AW-1:0]};
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check_eq("hold_valid", 64'(outValid), 64'd1);
                check_eq("hold_addr", 64'(regOutAddr), 64'(hold_addr));
            end
            hold_pend = outValid && !outReady;
            hold_addr = regOutAddr;
            if (outValid && outReady) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 64'(outValid), 64'd0);
                end else begin
                    exp_e = exp_q.pop_front();
                    n_out++;
                    $display("[TB] out #%0d addr=0x%012h exp=0x%012h", n_out, regOutAddr, exp_e[AW-1:0]);
                    check_eq("sb_addr", 64'(regOutAddr), 64'(exp_e[AW-1:0]));
`ifdef EXAGU_WRAPCHK_EN
                    check_eq("sb_fault", 64'(outFault), 64'(exp_e[AW]));
`endif
                end
            end
            if (inValid && inReady) begin
                exp_q.push_back(ref_agu(regValRm, regValRi, idUIxt, addrEnJq));
            end
        end
    end

    task automatic run_single(input string tag, input logic [AW-1:0] b, input logic [AW-1:0] x,
                              input logic [8:0] c, input logic en,
                              input logic [AW-1:0] exp_addr, input logic exp_fault);
        regValRm = b;
        regValRi = x;
        idUIxt   = c;
        addrEnJq = en;
        outReady = 1'b1;
        inValid  = 1'b1;
        check_eq({tag, "_rdy"}, 64'(inReady), 64'd1);
        @(posedge clock); #1;
        inValid = 1'b0;
        check_eq({tag, "_lat1"}, 64'(outValid), 64'd0);
        @(posedge clock); #1;
        check_eq({tag, "_valid"}, 64'(outValid), 64'd1);
        check_eq({tag, "_addr"}, 64'(regOutAddr), 64'(exp_addr));
`ifdef EXAGU_WRAPCHK_EN
        check_eq({tag, "_fault"}, 64'(outFault), 64'(exp_fault));
`else
        if (exp_fault) $display("[TB] %s: wrap fault expected, port absent in this build", tag);
`endif
        @(posedge clock); #1;
        check_eq({tag, "_drain"}, 64'(outValid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        inValid  = 1'b0;
        outReady = 1'b1;
        regValRm = '0;
        regValRi = '0;
        idUIxt   = '0;
        addrEnJq = 1'b1;
        #1;
        check_eq("rst_outvalid", 64'(outValid), 64'd0);
        check_eq("rst_addr", 64'(regOutAddr), 64'd0);
        check_eq("rst_inready", 64'(inReady), 64'd1);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock); #1;
        check_eq("post_rst_outvalid", 64'(outValid), 64'd0);

        run_single("segcarry", 48'h0000_1000_FFF0, 48'h10, 9'h037, 1'b1, 48'h0000_1001_0070, 1'b0);
        run_single("sext_b",   48'h0000_0000_1000, 48'hFF, 9'h001, 1'b1, 48'h0000_0000_0FFE, 1'b0);
        run_single("zext_b",   48'h0000_0000_1000, 48'hFF, 9'h005, 1'b1, 48'h0000_0000_11FE, 1'b0);
        run_single("wrap32",   48'h0000_FFFF_FFF0, 48'h20, 9'h004, 1'b0, 48'h0000_0000_0010, 1'b1);
        run_single("full48",   48'h0000_FFFF_FFF0, 48'h20, 9'h004, 1'b1, 48'h0001_0000_0010, 1'b0);
        run_single("mod48",    48'hFFFF_FFFF_FFFF, 48'h1,  9'h1FC, 1'b1, 48'h0000_0000_0000, 1'b0);
        run_single("sext_w",   48'h0000_0001_0000, 48'h8000, 9'h012, 1'b1, 48'hFFFF_FFFF_0000, 1'b0);

        // Backpressure: capacity two, first result held until released.
        regValRm = '0;
        idUIxt   = 9'h034;
        addrEnJq = 1'b1;
        outReady = 1'b0;
        regValRi = 48'd1;
        inValid  = 1'b1;
        @(posedge clock); #1;
        check_eq("bp_rdy1", 64'(inReady), 64'd1);
        regValRi = 48'd2;
        @(posedge clock); #1;
        check_eq("bp_rdy2", 64'(inReady), 64'd0);
        check_eq("bp_first", 64'(regOutAddr), 64'd1);
        regValRi = 48'd3;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check_eq($sformatf("bp_stall_rdy%0d", k), 64'(inReady), 64'd0);
            check_eq($sformatf("bp_stall_v%0d", k), 64'(outValid), 64'd1);
            check_eq($sformatf("bp_stall_a%0d", k), 64'(regOutAddr), 64'd1);
        end
        outReady = 1'b1;
        @(posedge clock); #1;
        inValid = 1'b0;
        check_eq("bp_out2", 64'(regOutAddr), 64'd2);
        @(posedge clock); #1;
        check_eq("bp_v3", 64'(outValid), 64'd1);
        check_eq("bp_out3", 64'(regOutAddr), 64'd3);
        @(posedge clock); #1;
        check_eq("bp_empty", 64'(outValid), 64'd0);

        // Streaming: 8 back-to-back requests, results on 8 consecutive cycles.
        outReady = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                inValid  = 1'b1;
                regValRm = AW'({$urandom, $urandom});
                regValRi = AW'({$urandom, $urandom});
                idUIxt   = 9'($urandom);
                addrEnJq = 1'($urandom);
                check_eq($sformatf("stream_rdy%0d", c), 64'(inReady), 64'd1);
            end else begin
                inValid = 1'b0;
            end
            @(posedge clock); #1;
            check_eq($sformatf("stream_v%0d", c), 64'(outValid), 64'((c >= 1) && (c <= 8)));
        end

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            inValid  = ($urandom_range(3) != 0);
            outReady = ($urandom_range(2) != 0);
            regValRm = ($urandom_range(3) == 0) ? (48'hFFFF_FFFF_FFFF - AW'($urandom_range(255)))
                                                : AW'({$urandom, $urandom});
            regValRi = AW'({$urandom, $urandom});
            idUIxt   = 9'($urandom);
            addrEnJq = 1'($urandom);
            @(posedge clock); #1;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (exp_q.size() == 0 && !outValid) break;
            @(posedge clock); #1;
        end
        check_eq("drain_left", 64'(exp_q.size()), 64'd0);
        check_eq("drain_valid", 64'(outValid), 64'd0);

        // Reset with both stages occupied.
        outReady = 1'b0;
        regValRm = '0;
        idUIxt   = 9'h034;
        addrEnJq = 1'b1;
        regValRi = 48'd5;
        inValid  = 1'b1;
        @(posedge clock); #1;
        regValRi = 48'd6;
        @(posedge clock); #1;
        inValid = 1'b0;
        check_eq("rstmid_pre_valid", 64'(outValid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("rstmid_valid", 64'(outValid), 64'd0);
        check_eq("rstmid_addr", 64'(regOutAddr), 64'd0);
        check_eq("rstmid_rdy", 64'(inReady), 64'd1);
        @(posedge clock);
        #3 reset = 1'b1;
        outReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            check_eq($sformatf("rstmid_stale%0d", k), 64'(outValid), 64'd0);
        end
        run_single("after_rst", 48'h0000_0000_0100, 48'h3, 9'h036, 1'b1, 48'h0000_0000_010C, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
